// File: rtl/dmem_ws.sv
// dmem_ws: parametrised data memory with byte lanes, wait states and a ready handshake
module dmem_ws #(
  parameter int DW = 16,
  parameter int AW = 8,
  parameter int DEPTH = 64,
  parameter int WAIT = 0,
  parameter int INIT_N = 8,
  parameter logic [INIT_N*DW-1:0] INIT_VEC = {16'h0001, 16'hffff, 16'h0041, 16'h69c3,
                                              16'hc369, 16'h0005, 16'h0004, 16'hfffd}
) (
  input  logic            mem_clk,
  input  logic            reset,
  input  logic            req,
  input  logic            dwe,
  input  logic [DW/8-1:0] be,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata,
  output logic            ready,
  output logic            err
);
  localparam int BW = DW / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  typedef enum logic [1:0] {IDLE, WAITST, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic dwe_q, dwe_d;
  logic [BW-1:0] be_q, be_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic ready_q, ready_d;
  logic err_q, err_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic acc;
  logic a_dwe;
  logic [BW-1:0] a_be;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic [IW-1:0] a_idx;
  logic in_rng;
  // with no wait states the access happens on the accept edge, so use the live inputs then
  assign a_dwe   = (state_q == IDLE) ? dwe   : dwe_q;
  assign a_be    = (state_q == IDLE) ? be    : be_q;
  assign a_addr  = (state_q == IDLE) ? addr  : addr_q;
  assign a_wdata = (state_q == IDLE) ? wdata : wdata_q;
  assign a_idx   = a_addr[IW-1:0];
  assign in_rng  = 32'(a_addr) < DEPTH;
  assign rdata   = rdata_q;
  assign ready   = ready_q;
  assign err     = err_q;
  // handshake sequencing: accept in IDLE, count down wait states, one RESP cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dwe_d   = dwe_q;
    be_d    = be_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    acc     = 1'b0;
    unique case (state_q)
      IDLE: if (req) begin
        dwe_d   = dwe;
        be_d    = be;
        addr_d  = addr;
        wdata_d = wdata;
        cnt_d   = 4'(WAIT);
        acc     = (WAIT == 0);
        state_d = (WAIT == 0) ? RESP : WAITST;
      end
      WAITST: begin
        cnt_d   = cnt_q - 4'd1;
        acc     = (cnt_q == 4'd1);
        state_d = (cnt_q == 4'd1) ? RESP : WAITST;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  // memory access performed on the committing edge; out-of-range touches nothing
  always_comb begin
    mem_d   = mem_q;
    rdata_d = rdata_q;
    ready_d = acc;
    err_d   = acc && !in_rng;
    if (acc && !a_dwe) rdata_d = in_rng ? mem_q[a_idx] : '0;
    if (acc && a_dwe && in_rng)
      for (int j = 0; j < BW; j++)
        if (a_be[j]) mem_d[a_idx][8*j +: 8] = a_wdata[8*j +: 8];
  end
  // control and response registers; reset aborts any pending access
  always_ff @(posedge mem_clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
    end
  end
  // latched request fields need no reset
  always_ff @(posedge mem_clk) begin
    dwe_q   <= dwe_d;
    be_q    <= be_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
  end
  // storage: reset reloads only the preload window, other words keep their contents
  always_ff @(posedge mem_clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!reset) begin
        if (i < INIT_N) mem_q[i] <= INIT_VEC[i*DW +: DW];
      end else begin
        mem_q[i] <= mem_d[i];
      end
    end
  end
endmodule

// File: tb/tb_dmem_ws.sv
// tb_dmem_ws: directed and random checks of dmem_ws against a word-array reference model
module tb_dmem_ws;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [3:0] req = '0;
  logic dwe = 1'b0;
  logic [1:0] be = '0;
  logic [7:0] addr = '0;
  logic [15:0] wdata = '0;
  logic [15:0] rdata [4];
  logic ready [4];
  logic err [4];
  int errors = 0;
  int checks = 0;
  int wt [4] = '{0, 2, 3, 4};
  logic [15:0] pre [8] = '{16'hfffd, 16'h0004, 16'h0005, 16'hc369,
                          16'h69c3, 16'h0041, 16'hffff, 16'h0001};
  logic [15:0] mm [4][64];
  bit vld [4][64];
  logic [15:0] rd_m [4];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    dmem_ws #(.WAIT(g == 0 ? 0 : g + 1)) u_dut (
      .mem_clk(clk), .reset(reset), .req(req[g]), .dwe(dwe), .be(be),
      .addr(addr), .wdata(wdata), .rdata(rdata[g]), .ready(ready[g]), .err(err[g]));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      rd_m[i] = '0;
      for (int w = 0; w < 8; w++) begin
        mm[i][w] = pre[w];
        vld[i][w] = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk) reset = 1'b0;
    @(negedge clk) reset = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_rdata%0d", i), rdata[i], 0);
      chk($sformatf("rst_ready%0d", i), ready[i], 0);
      chk($sformatf("rst_err%0d", i), err[i], 0);
    end
  endtask

  task automatic access(input int i, input bit we, input logic [1:0] b,
                        input logic [7:0] a, input logic [15:0] wd);
    bit oor;
    @(negedge clk);
    dwe = we; be = b; addr = a; wdata = wd; req[i] = 1'b1;
    @(posedge clk); #1;
    req[i] = 1'b0;
    oor = a >= 8'd64;
    if (we && !oor) begin
      if (b[0]) mm[i][a][7:0] = wd[7:0];
      if (b[1]) mm[i][a][15:8] = wd[15:8];
    end
    if (!we) rd_m[i] = oor ? 16'h0 : mm[i][a];
    for (int c = 0; c <= wt[i] + 1; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      chk($sformatf("ready%0d_a%0d_c%0d", i, a, c), ready[i], c == wt[i]);
      chk($sformatf("err%0d_a%0d_c%0d", i, a, c), err[i], (c == wt[i]) && oor);
      if (c == wt[i]) chk($sformatf("rdata%0d_a%0d", i, a), rdata[i], rd_m[i]);
    end
  endtask

  initial begin
    int r1, r2, nrdy;
    repeat (2) @(posedge clk);
    do_reset();
    // preload image readback
    for (int w = 0; w < 8; w++) access(0, 1'b0, 2'b00, 8'(w), 16'h0);
    // byte lanes
    access(0, 1'b1, 2'b01, 8'd3, 16'haabb);
    access(0, 1'b0, 2'b00, 8'd3, 16'h0);
    chk("be_lo", rdata[0], 16'hc3bb);
    access(0, 1'b1, 2'b10, 8'd3, 16'haabb);
    access(0, 1'b0, 2'b00, 8'd3, 16'h0);
    chk("be_hi", rdata[0], 16'haabb);
    // out of range
    access(0, 1'b1, 2'b11, 8'd64, 16'h1234);
    access(0, 1'b0, 2'b00, 8'd64, 16'h0);
    access(0, 1'b0, 2'b00, 8'd0, 16'h0);
    chk("oor_mem0", rdata[0], 16'hfffd);
    // WAIT=3 with req held: ready 3 edges after accept, period 5
    @(negedge clk);
    dwe = 1'b0; addr = 8'd5; req[2] = 1'b1;
    @(posedge clk); #1;
    r1 = -1; r2 = -1; nrdy = 0;
    for (int c = 0; c <= 12; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      if (ready[2]) begin
        nrdy++;
        if (r1 < 0) r1 = c; else if (r2 < 0) r2 = c;
      end
    end
    @(negedge clk) req[2] = 1'b0;
    repeat (6) @(posedge clk);
    rd_m[2] = mm[2][5];
    chk("per_first", r1, 3);
    chk("per_second", r2, 8);
    chk("per_count", nrdy, 2);
    chk("per_rdata", rdata[2], rd_m[2]);
    // WAIT=2: inputs and req wiggled while busy are ignored
    @(negedge clk);
    dwe = 1'b0; addr = 8'd3; req[1] = 1'b1;
    @(posedge clk); #1;
    rd_m[1] = mm[1][3];
    chk("busy_c0", ready[1], 0);
    @(negedge clk);
    dwe = 1'b1; addr = 8'd4; wdata = 16'hdead; be = 2'b11;
    @(posedge clk); #1;
    chk("busy_c1", ready[1], 0);
    @(posedge clk); #1;
    chk("busy_c2", ready[1], 1);
    chk("busy_rdata", rdata[1], rd_m[1]);
    @(negedge clk) addr = 8'd5;
    @(posedge clk); #1;
    req[1] = 1'b0;
    chk("busy_c3", ready[1], 0);
    for (int c = 4; c <= 6; c++) begin
      @(posedge clk); #1;
      chk($sformatf("busy_c%0d", c), ready[1], 0);
    end
    access(1, 1'b0, 2'b00, 8'd4, 16'h0);
    access(1, 1'b0, 2'b00, 8'd5, 16'h0);
    // WAIT=4: reset two edges after accept aborts the write
    access(3, 1'b1, 2'b11, 8'd10, 16'h0abc);
    vld[3][10] = 1'b1;
    @(negedge clk);
    dwe = 1'b1; be = 2'b11; addr = 8'd10; wdata = 16'h5555; req[3] = 1'b1;
    @(posedge clk); #1;
    req[3] = 1'b0;
    chk("mid_c0", ready[3], 0);
    @(posedge clk); #1;
    chk("mid_c1", ready[3], 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    chk("mid_c2", ready[3], 0);
    @(negedge clk) reset = 1'b1;
    model_reset();
    for (int c = 3; c <= 9; c++) begin
      @(posedge clk); #1;
      chk($sformatf("mid_c%0d", c), ready[3], 0);
    end
    chk("mid_rdata", rdata[3], 0);
    access(3, 1'b0, 2'b00, 8'd10, 16'h0);
    chk("mid_keep", rdata[3], 16'h0abc);
    access(3, 1'b0, 2'b00, 8'd0, 16'h0);
    chk("mid_pre", rdata[3], 16'hfffd);
    // random mix across all wait configurations
    for (int n = 0; n < 40; n++) begin
      int i;
      bit we;
      logic [1:0] b;
      logic [7:0] a;
      i = $urandom_range(0, 3);
      a = 8'($urandom_range(0, 70));
      we = 1'($urandom_range(0, 1));
      b = 2'($urandom_range(0, 3));
      if (a < 8'd64 && !vld[i][a]) begin we = 1'b1; b = 2'b11; end
      if (we && a < 8'd64 && b == 2'b11) vld[i][a] = 1'b1;
      access(i, we, b, a, 16'($urandom));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
